// File: rtl/gpu_rect_addrgen.sv
`default_nettype none
// ============================================================================
// Module  : gpu_rect_addrgen
// Brief   : Walks an inclusive rectangle row-major and emits one linear
//           framebuffer write per pixel via a single valid/ready register.
//           Optional macro RECT_CLIP_EN clamps out-of-range bounds instead of
//           rejecting the request.
// Rev     : 1.0  initial release
// ============================================================================

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module gpu_rect_addrgen #(
  parameter int COLOR_BITS = 8
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic [`WIDTH_BITS-1:0]                x0,
  input  logic [`WIDTH_BITS-1:0]                x1,
  input  logic [`HEIGHT_BITS-1:0]               y0,
  input  logic [`HEIGHT_BITS-1:0]               y1,
  input  logic [COLOR_BITS-1:0]                 color,
  output logic [`HEIGHT_BITS-1:0]               addressy,
  input  logic [`HEIGHT_BITS+`WIDTH_BITS:0]     rtpaddy,
  output logic                                  wr_valid,
  input  logic                                  wr_ready,
  output logic [`HEIGHT_BITS+`WIDTH_BITS:0]     wr_addr,
  output logic [COLOR_BITS-1:0]                 wr_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int WB = `WIDTH_BITS;
  localparam int HB = `HEIGHT_BITS;
  localparam int AW = `HEIGHT_BITS + `WIDTH_BITS + 1;
  localparam logic [WB-1:0] XMAX = WB'(`WIDTH - 1);
  localparam logic [HB-1:0] YMAX = HB'(`HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [WB-1:0]         x0_q, x1_q, x_cnt_q;
  logic [HB-1:0]         y1_q, y_cnt_q;
  logic [COLOR_BITS-1:0] color_q;
  logic                  wr_valid_q, busy_q, done_q, err_q;
  logic [AW-1:0]         wr_addr_q;
  logic [COLOR_BITS-1:0] wr_data_q;

  logic [WB-1:0]         cx0, cx1;
  logic [HB-1:0]         cy0, cy1;
  logic [AW-1:0]         pix_addr_d;
  logic                  load_d;
`ifndef RECT_CLIP_EN
  logic                  bad_bounds;
`endif

  always_comb begin
`ifdef RECT_CLIP_EN
    cx0 = (x0 > XMAX) ? XMAX : x0;
    cx1 = (x1 > XMAX) ? XMAX : x1;
    cy0 = (y0 > YMAX) ? YMAX : y0;
    cy1 = (y1 > YMAX) ? YMAX : y1;
`else
    cx0 = x0;
    cx1 = x1;
    cy0 = y0;
    cy1 = y1;
    bad_bounds = (x0 > XMAX) || (x1 > XMAX) || (y0 > YMAX) || (y1 > YMAX);
`endif
  end

  // The row-offset LUT answers for addressy in the same cycle, so the
  // address of the current counter position is ready before the edge.
  assign pix_addr_d = rtpaddy + {{(AW-WB){1'b0}}, x_cnt_q};
  assign load_d     = !wr_valid_q || wr_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      color_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
`ifndef RECT_CLIP_EN
            if (bad_bounds) begin
              err_q <= 1'b1;
            end else
`endif
            begin
              x0_q    <= cx0;
              x1_q    <= cx1;
              y1_q    <= cy1;
              x_cnt_q <= cx0;
              y_cnt_q <= cy0;
              color_q <= color;
              busy_q  <= 1'b1;
              if ((cx0 > cx1) || (cy0 > cy1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          if (load_d) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= pix_addr_d;
            wr_data_q  <= color_q;
            if (x_cnt_q == x1_q) begin
              if (y_cnt_q == y1_q) begin
                state_q <= ST_DRAIN;
              end else begin
                x_cnt_q <= x0_q;
                y_cnt_q <= y_cnt_q + HB'(1);
              end
            end else begin
              x_cnt_q <= x_cnt_q + WB'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addressy = y_cnt_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire
